// File: rtl/count_seq_arbiter.sv
// Two-requester round-robin arbiter that grants a shared counter
// for one clear-count-done sequence per grant.
module count_seq_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic             x,
  output logic [1:0]       gnt,
  output logic [WIDTH-1:0] ctr,
  output logic [1:0]       done,
  output logic             abort,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    COUNT,
    DONE
  } state_t;

  localparam logic [WIDTH-1:0] TC = '1;

  state_t state;
  state_t state_nx;

  logic owner;
  logic owner_nx;
  logic last_served;
  logic abort_q;

  logic ld_owner;
  logic clr_ctr;
  logic inc_ctr;
  logic set_abort;
  logic upd_last;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and datapath controls
  always_comb begin
    state_nx  = state;
    ld_owner  = 1'b0;
    clr_ctr   = 1'b0;
    inc_ctr   = 1'b0;
    set_abort = 1'b0;
    upd_last  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req != 2'b00) begin
          state_nx = CLEAR;
          ld_owner = 1'b1;
        end
      end
      CLEAR: begin
        clr_ctr  = 1'b1;
        state_nx = COUNT;
      end
      COUNT: begin
        if (!req[owner]) begin
          state_nx  = IDLE;
          set_abort = 1'b1;
        end else if (x) begin
          if (ctr == TC) begin
            state_nx = DONE;
            upd_last = 1'b1;
          end else begin
            inc_ctr = 1'b1;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Round-robin pick: a tie goes to whoever was not served last
  always_comb begin
    owner_nx = owner;
    unique case (1'b1)
      (req == 2'b01): owner_nx = 1'b0;
      (req == 2'b10): owner_nx = 1'b1;
      (req == 2'b11): owner_nx = ~last_served;
      default:        owner_nx = owner;
    endcase
  end

  // Owner, history, counter and abort pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner       <= 1'b0;
      last_served <= 1'b1;
      ctr         <= '0;
      abort_q     <= 1'b0;
    end else begin
      abort_q <= set_abort;
      if (ld_owner) begin
        owner <= owner_nx;
      end
      if (upd_last) begin
        last_served <= owner;
      end
      if (clr_ctr) begin
        ctr <= '0;
      end else if (inc_ctr) begin
        ctr <= ctr + 1'b1;
      end
    end
  end

  // Outputs decoded from registered state and owner only
  always_comb begin
    gnt  = 2'b00;
    done = 2'b00;
    if (state != IDLE) begin
      gnt[owner] = 1'b1;
    end
    if (state == DONE) begin
      done[owner] = 1'b1;
    end
  end

  assign busy  = (state != IDLE);
  assign abort = abort_q;

endmodule
